// File: rtl/ti_sbox_seq_if.sv
// Handshake and stage-network bundle for the TI S-box sequencer.
// The sequencer uses the slave side; the environment and stage network use master.
interface ti_sbox_seq_if #(
    parameter int NSH    = 3,
    parameter int W      = 4,
    parameter int NSTAGE = 2
);
    localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [NSH*W-1:0]       in_shares;
    logic                   rnd_req;
    logic                   rnd_valid;
    logic [(NSH-1)*W-1:0]   rnd_data;
    logic [SW-1:0]          stg_sel;
    logic [NSH*W-1:0]       stg_in;
    logic [NSH*W-1:0]       stg_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [NSH*W-1:0]       out_shares;
    logic                   busy;

    modport slave (
        input  in_valid, in_shares, rnd_valid, rnd_data, stg_out, out_ready,
        output in_ready, rnd_req, stg_sel, stg_in, out_valid, out_shares, busy
    );

    modport master (
        output in_valid, in_shares, rnd_valid, rnd_data, stg_out, out_ready,
        input  in_ready, rnd_req, stg_sel, stg_in, out_valid, out_shares, busy
    );
endinterface

// File: rtl/ti_sbox_seq.sv
// Sequencer for a multi-stage threshold-implementation 4-bit S-box.
// Remasks one shared input, steps it through NSTAGE registered stages, returns it.
module ti_sbox_seq #(
    parameter int NSH    = 3,
    parameter int W      = 4,
    parameter int NSTAGE = 2
) (
    input  logic         clk,
    input  logic         rst,
    ti_sbox_seq_if.slave bus
);
    localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [SW-1:0] LAST = SW'(NSTAGE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RND,
        EVAL,
        DONE
    } state_t;

    state_t           state_q;
    logic [NSH*W-1:0] sh_q;
    logic [NSH*W-1:0] sh_remask_d;
    logic [W-1:0]     rsum_d;
    logic [SW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             rnd_req_q;
    logic             eval_q;
    logic             out_valid_q;
    logic             busy_q;

    // Remask: every share but the last takes its own mask, the last takes
    // the XOR of all masks so the unshared value is unchanged.
    always_comb begin
        rsum_d      = '0;
        sh_remask_d = sh_q;
        for (int k = 0; k < NSH - 1; k++) begin
            sh_remask_d[k*W +: W] = sh_q[k*W +: W] ^ bus.rnd_data[k*W +: W];
            rsum_d                = rsum_d ^ bus.rnd_data[k*W +: W];
        end
        sh_remask_d[(NSH-1)*W +: W] = sh_q[(NSH-1)*W +: W] ^ rsum_d;
    end

    // Operation FSM with registered handshake flags; sh_q is the glitch barrier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            rnd_req_q   <= 1'b0;
            eval_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh_q       <= bus.in_shares;
                        state_q    <= RND;
                        in_ready_q <= 1'b0;
                        rnd_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                RND: begin
                    if (bus.rnd_valid) begin
                        sh_q      <= sh_remask_d;
                        cnt_q     <= '0;
                        state_q   <= EVAL;
                        rnd_req_q <= 1'b0;
                        eval_q    <= 1'b1;
                    end
                end
                EVAL: begin
                    sh_q <= bus.stg_out;
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        eval_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        sh_q        <= '0;
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Share buses are gated by registered state flags so idle buses carry zeros.
    always_comb begin
        bus.stg_in     = eval_q ? sh_q : '0;
        bus.out_shares = out_valid_q ? sh_q : '0;
    end

    assign bus.stg_sel   = cnt_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.rnd_req   = rnd_req_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ti_sbox_seq.sv
// Self-checking bench for ti_sbox_seq with a behavioural TI stage network.
// Scoreboard queue of expected outputs, table-driven S-box sweep, corner cases.
module tb_ti_sbox_seq;
    localparam int NSH    = 3;
    localparam int W      = 4;
    localparam int NSTAGE = 2;

    typedef struct {
        logic [11:0] sh;
        logic [3:0]  x;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0] x;
        logic [3:0] m0;
        logic [3:0] m1;
        logic [7:0] r;
        logic [3:0] sx;
    } vec_t;

    logic clk;
    logic rst;
    bit   passthru;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];
    vec_t tv[16];

    logic [3:0] sbox_tab [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    ti_sbox_seq_if #(.NSH(NSH), .W(W), .NSTAGE(NSTAGE)) bus ();

    ti_sbox_seq #(.NSH(NSH), .W(W), .NSTAGE(NSTAGE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage 0 yields shares of S(x)^A, stage 1 removes A and permutes shares.
    function automatic logic [11:0] stage_f(input logic [11:0] s,
                                            input logic sel, input bit pt);
        logic [3:0] a, b, c;
        a = s[3:0];
        b = s[7:4];
        c = s[11:8];
        if (pt) return s;
        if (!sel) return {c, b, sbox_tab[a ^ b ^ c] ^ b ^ c ^ 4'hA};
        return {a ^ 4'hA, c, b};
    endfunction

    function automatic logic [11:0] model_op(input logic [11:0] sh,
                                             input logic [7:0] r, input bit pt);
        logic [11:0] m;
        logic [3:0]  rs;
        rs = r[3:0] ^ r[7:4];
        m  = {sh[11:8] ^ rs, sh[7:4] ^ r[7:4], sh[3:0] ^ r[3:0]};
        for (int i = 0; i < NSTAGE; i++) m = stage_f(m, i[0], pt);
        return m;
    endfunction

    always_comb bus.stg_out = stage_f(bus.stg_in, bus.stg_sel, passthru);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sample at the falling edge; every sampled cycle checks the idle-bus rule.
    task automatic tick();
        @(negedge clk);
        n_cmp++;
        assert (((bus.in_ready || bus.rnd_req || bus.out_valid) ? (bus.stg_in == '0) : 1'b1)
                && (bus.out_valid || bus.out_shares == '0)
                && (bus.busy == !bus.in_ready))
        else begin
            n_bad++;
            $display("FAIL idle_bus: stg_in=%h out_shares=%h busy=%b in_ready=%b cycle %0d",
                     bus.stg_in, bus.out_shares, bus.busy, bus.in_ready, cyc);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One operation: push the expectation, drive, wait for output, pop and compare.
    task automatic send(input logic [11:0] sh, input logic [7:0] r, input int rdly,
                        input int odly, input logic [11:0] esh, input logic [3:0] ex);
        exp_t        e;
        int          tv_cyc;
        bit          seen;
        logic [11:0] hold;
        e.sh  = esh;
        e.x   = ex;
        e.cyc = cyc + 2 + NSTAGE + rdly;
        sb_q.push_back(e);
        bus.in_shares = sh;
        bus.rnd_data  = r;
        bus.rnd_valid = (rdly == 0);
        bus.out_ready = (odly == 0);
        bus.in_valid  = 1'b1;
        tick();
        chk("in_ready_acc", 32'(bus.in_ready), 32'd1);
        adv();
        bus.in_valid  = 1'b0;
        bus.in_shares = 12'($urandom);
        for (int j = 0; j < rdly; j++) begin
            tick();
            chk("rnd_req_hold", 32'(bus.rnd_req), 32'd1);
            chk("no_eval_in_rnd", 32'(bus.stg_in), 32'd0);
            adv();
        end
        bus.rnd_valid = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
            else adv();
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_timeout: got no out_valid expected one by cycle %0d", e.cyc);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        tv_cyc = cyc;
        hold   = bus.out_shares;
        for (int j = 0; j < odly; j++) begin
            adv();
            bus.in_valid  = j[0];
            bus.in_shares = 12'($urandom);
            tick();
            chk("stall_shares", 32'(bus.out_shares), 32'(hold));
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        if (odly > 0) begin
            adv();
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            tick();
        end
        e = sb_q.pop_front();
        chk("out_shares", 32'(bus.out_shares), 32'(e.sh));
        chk("out_xor", 32'(bus.out_shares[3:0] ^ bus.out_shares[7:4] ^ bus.out_shares[11:8]),
            32'(e.x));
        chk("latency", 32'(tv_cyc), 32'(e.cyc));
        adv();
        chk("in_ready_ret", 32'(bus.in_ready), 32'd1);
        chk("valid_drop", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [11:0] sh;
        n_cmp         = 0;
        n_bad         = 0;
        passthru      = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_shares = '0;
        bus.rnd_valid = 1'b0;
        bus.rnd_data  = '0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 16; i++) begin
            tv[i].x  = 4'(i);
            tv[i].m0 = 4'($urandom);
            tv[i].m1 = 4'($urandom);
            tv[i].r  = 8'($urandom);
            tv[i].sx = sbox_tab[i];
        end

        adv();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_rnd_req", 32'(bus.rnd_req), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_stg_sel", 32'(bus.stg_sel), 32'd0);
        chk("rst_stg_in", 32'(bus.stg_in), 32'd0);
        chk("rst_out_shares", 32'(bus.out_shares), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        adv();
        rst = 1'b0;
        adv();

        passthru = 1'b1;
        send(12'h900, 8'h35, 0, 0, 12'hF35, 4'h9);
        passthru = 1'b0;

        for (int i = 0; i < 16; i++) begin
            sh = {tv[i].m1, tv[i].m0, tv[i].x ^ tv[i].m0 ^ tv[i].m1};
            send(sh, tv[i].r, 0, 0, model_op(sh, tv[i].r, 1'b0), tv[i].sx);
        end

        sh = 12'h5A3;
        send(sh, 8'hC6, 5, 0, model_op(sh, 8'hC6, 1'b0), sbox_tab[4'h5 ^ 4'hA ^ 4'h3]);

        sh = 12'h3E7;
        send(sh, 8'h19, 0, 7, model_op(sh, 8'h19, 1'b0), sbox_tab[4'h3 ^ 4'hE ^ 4'h7]);

        bus.in_shares = 12'h7C2;
        bus.rnd_data  = 8'hA5;
        bus.rnd_valid = 1'b1;
        bus.in_valid  = 1'b1;
        adv();
        bus.in_valid = 1'b0;
        adv();
        adv();
        rst = 1'b1;
        tick();
        chk("rst_eval_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_eval_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_eval_stg_in", 32'(bus.stg_in), 32'd0);
        chk("rst_eval_busy", 32'(bus.busy), 32'd0);
        adv();
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("discarded_op", 32'(bus.out_valid), 32'd0);
            adv();
        end

        sh = 12'hB14;
        send(sh, 8'h7E, 0, 0, model_op(sh, 8'h7E, 1'b0), sbox_tab[4'hB ^ 4'h1 ^ 4'h4]);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
